// File: rtl/wrap_alarm_pkg.sv
// Shared types, default timing constants and pitch helper for the wrap alarm player.
package wrap_alarm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BEEP,
        GAP
    } state_t;

    localparam int unsigned BEEP_CYC_DEF  = 20_000_000;
    localparam int unsigned GAP_CYC_DEF   = 10_000_000;
    localparam int unsigned BASE_HALF_DEF = 50_000;
    localparam int unsigned STEP_HALF_DEF = 4_000;

    // Higher object index -> shorter half-period -> higher pitch.
    function automatic int unsigned half_period(input int unsigned idx,
                                                input int unsigned base,
                                                input int unsigned step);
        return base - idx * step;
    endfunction

endpackage

// File: rtl/wrap_alarm_fifo.sv
// Synchronous index FIFO between the wrap priority encoder and the tone player.
module wrap_alarm_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wrap_alarm_sequencer.sv
// Ordered alarm player: queues counter-wrap pulses and plays one pitched burst per event.
// Optional WRAP_ALARM_DOUBLE_EN plays every event as two bursts with the same pitch.
module wrap_alarm_sequencer
    import wrap_alarm_pkg::*;
#(
    parameter int unsigned N_OBJ      = 10,
    parameter int unsigned IDX_W      = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned BEEP_CYC   = BEEP_CYC_DEF,
    parameter int unsigned GAP_CYC    = GAP_CYC_DEF,
    parameter int unsigned BASE_HALF  = BASE_HALF_DEF,
    parameter int unsigned STEP_HALF  = STEP_HALF_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic             mute,
    input  logic [N_OBJ-1:0] wrap_evt,
    output logic             buzzer,
    output logic             busy,
    output logic [IDX_W-1:0] cur_idx,
    output logic             coalesced
);
    localparam int unsigned HALF_W  = IDX_W + 17;
    localparam logic [31:0] BEEP_LD = 32'(BEEP_CYC - 1);
    localparam logic [31:0] GAP_LD  = 32'(GAP_CYC - 1);

    logic [N_OBJ-1:0]  pending;
    logic [N_OBJ-1:0]  push_mask;
    logic [IDX_W-1:0]  push_idx;
    logic              found;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [IDX_W-1:0]  fifo_dout;

    state_t            state, state_n;
    logic              tone, tone_n;
    logic [IDX_W-1:0]  cur_idx_n;
    logic [HALF_W-1:0] half_r, half_n;
    logic [HALF_W-1:0] tone_cnt, tone_cnt_n;
    logic [31:0]       beep_cnt, beep_n;
    logic [31:0]       gap_cnt, gap_n;
`ifdef WRAP_ALARM_DOUBLE_EN
    logic              rep, rep_n;
`endif

    assign buzzer = tone & ~mute;
    assign busy   = (state != IDLE);

    // Lowest pending index wins the single push slot each cycle.
    always_comb begin
        push_idx  = '0;
        push_mask = '0;
        found     = 1'b0;
        for (int i = 0; i < int'(N_OBJ); i++) begin
            if (pending[i] && !found) begin
                found        = 1'b1;
                push_idx     = IDX_W'(i);
                push_mask[i] = 1'b1;
            end
        end
        push = enable && found && !fifo_full;
        if (!push) push_mask = '0;
    end

    // A pulse landing on the bit being pushed this cycle re-arms it without counting as a merge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pending   <= '0;
            coalesced <= 1'b0;
        end else if (!enable) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~push_mask) | wrap_evt;
            if (|(wrap_evt & pending & ~push_mask)) coalesced <= 1'b1;
        end
    end

    wrap_alarm_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .flush (!enable),
        .push  (push),
        .pop   (pop),
        .din   (push_idx),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            tone     <= 1'b0;
            cur_idx  <= '0;
            half_r   <= '0;
            tone_cnt <= '0;
            beep_cnt <= '0;
            gap_cnt  <= '0;
`ifdef WRAP_ALARM_DOUBLE_EN
            rep      <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            tone     <= tone_n;
            cur_idx  <= cur_idx_n;
            half_r   <= half_n;
            tone_cnt <= tone_cnt_n;
            beep_cnt <= beep_n;
            gap_cnt  <= gap_n;
`ifdef WRAP_ALARM_DOUBLE_EN
            rep      <= rep_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        tone_n     = tone;
        cur_idx_n  = cur_idx;
        half_n     = half_r;
        tone_cnt_n = tone_cnt;
        beep_n     = beep_cnt;
        gap_n      = gap_cnt;
        pop        = 1'b0;
`ifdef WRAP_ALARM_DOUBLE_EN
        rep_n      = rep;
`endif
        if (!enable) begin
            state_n = IDLE;
            tone_n  = 1'b0;
`ifdef WRAP_ALARM_DOUBLE_EN
            rep_n   = 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        cur_idx_n  = fifo_dout;
                        half_n     = HALF_W'(half_period(32'(fifo_dout), BASE_HALF, STEP_HALF));
                        tone_cnt_n = half_n - 1'b1;
                        beep_n     = BEEP_LD;
                        tone_n     = 1'b1;
                        state_n    = BEEP;
`ifdef WRAP_ALARM_DOUBLE_EN
                        rep_n      = 1'b0;
`endif
                    end
                end
                BEEP: begin
                    if (tone_cnt == '0) begin
                        tone_n     = ~tone;
                        tone_cnt_n = half_r - 1'b1;
                    end else begin
                        tone_cnt_n = tone_cnt - 1'b1;
                    end
                    beep_n = beep_cnt - 1'b1;
                    if (beep_cnt == '0) begin
                        tone_n  = 1'b0;
                        beep_n  = beep_cnt;
                        gap_n   = GAP_LD;
                        state_n = GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
`ifdef WRAP_ALARM_DOUBLE_EN
                        // First pass restarts the burst at the same pitch; second pass retires the event.
                        if (!rep) begin
                            rep_n      = 1'b1;
                            beep_n     = BEEP_LD;
                            tone_cnt_n = half_r - 1'b1;
                            tone_n     = 1'b1;
                            state_n    = BEEP;
                        end else begin
                            rep_n   = 1'b0;
                            state_n = IDLE;
                        end
`else
                        state_n = IDLE;
`endif
                    end else begin
                        gap_n = gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    tone_n  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wrap_alarm_sequencer.sv
// Directed bench for wrap_alarm_sequencer with short burst/gap timing.
module tb_wrap_alarm_sequencer;
    localparam int N_OBJ = 10;
    localparam int IDX_W = 4;
    localparam int BEEP  = 64;
    localparam int GAP   = 8;
    localparam int BASE  = 20;
    localparam int STEP  = 2;
`ifdef WRAP_ALARM_DOUBLE_EN
    localparam int NPASS = 2;
`else
    localparam int NPASS = 1;
`endif
    localparam int EVT = NPASS * (BEEP + GAP);

    logic             clk = 1'b0;
    logic             rstn;
    logic             enable;
    logic             mute;
    logic [N_OBJ-1:0] wrap_evt;
    logic             buzzer;
    logic             busy;
    logic [IDX_W-1:0] cur_idx;
    logic             coalesced;

    int vectors = 0;
    int miscompares = 0;

    wrap_alarm_sequencer #(
        .N_OBJ      (N_OBJ),
        .IDX_W      (IDX_W),
        .FIFO_DEPTH (4),
        .BEEP_CYC   (BEEP),
        .GAP_CYC    (GAP),
        .BASE_HALF  (BASE),
        .STEP_HALF  (STEP)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .enable    (enable),
        .mute      (mute),
        .wrap_evt  (wrap_evt),
        .buzzer    (buzzer),
        .busy      (busy),
        .cur_idx   (cur_idx),
        .coalesced (coalesced)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after the pop edge; walks the whole event and checks the idle cycle after it.
    task automatic check_burst(input int idx);
        int half, bad, j;
        logic exp_bz;
        half = BASE - idx * STEP;
        bad  = 0;
        for (int k = 0; k < EVT; k++) begin
            j = k % (BEEP + GAP);
            exp_bz = (j < BEEP) && (((j / half) % 2) == 0);
            if (buzzer !== exp_bz || busy !== 1'b1 || cur_idx !== idx[IDX_W-1:0]) bad++;
            step();
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL burst_idx%0d: %0d bad cycles, required 0", idx, bad);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_end_idx%0d: got %b, required 0", idx, busy);
        end
    endtask

    task automatic pulse(input logic [N_OBJ-1:0] v);
        wrap_evt = v;
        step();
        wrap_evt = '0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; enable = 1'b1; mute = 1'b0; wrap_evt = '0;
        repeat (3) step();
        vectors += 4;
        if (buzzer !== 1'b0) begin miscompares++; $display("FAIL rst_buzzer: got %b, required 0", buzzer); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b, required 0", busy); end
        if (cur_idx !== 4'd0) begin miscompares++; $display("FAIL rst_cur_idx: got %0d, required 0", cur_idx); end
        if (coalesced !== 1'b0) begin miscompares++; $display("FAIL rst_coalesced: got %b, required 0", coalesced); end
        rstn = 1'b1;
        repeat (5) step();
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b, required 0", busy); end
    endtask

    task automatic test_single();
        pulse(10'b00_0000_1000);
        step();
        vectors += 2;
        if (buzzer !== 1'b0) begin miscompares++; $display("FAIL lat1_buzzer: got %b, required 0", buzzer); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL lat1_busy: got %b, required 0", busy); end
        step();
        vectors++;
        if (buzzer !== 1'b1) begin miscompares++; $display("FAIL lat2_buzzer: got %b, required 1", buzzer); end
        check_burst(3);
        repeat (5) step();
    endtask

    task automatic test_simultaneous();
        pulse(10'b00_0010_0101);
        step();
        step();
        check_burst(0);
        step();
        check_burst(2);
        step();
        check_burst(5);
        vectors++;
        if (coalesced !== 1'b0) begin miscompares++; $display("FAIL simul_coalesced: got %b, required 0", coalesced); end
        repeat (5) step();
    endtask

    // Idx 0 plays while 1..4 fill the 4-deep queue; the two bit-7 pulses merge into one event.
    task automatic test_coalesce();
        int seq[$];
        int exp_seq[6] = '{0, 1, 2, 3, 4, 7};
        logic prev;
        prev = busy;
        for (int c = 0; c < 6 * (EVT + 1) + 40; c++) begin
            wrap_evt = (c == 0) ? 10'h01F : ((c == 6 || c == 7) ? 10'h080 : 10'h000);
            step();
            if (busy && !prev) seq.push_back(int'(cur_idx));
            prev = busy;
            if (c == 6) begin
                vectors++;
                if (coalesced !== 1'b0) begin miscompares++; $display("FAIL coal_first: got %b, required 0", coalesced); end
            end
            if (c == 8) begin
                vectors++;
                if (coalesced !== 1'b1) begin miscompares++; $display("FAIL coal_set: got %b, required 1", coalesced); end
            end
        end
        wrap_evt = '0;
        vectors++;
        if (seq.size() != 6) begin miscompares++; $display("FAIL coal_count: got %0d bursts, required 6", seq.size()); end
        for (int i = 0; i < 6 && i < seq.size(); i++) begin
            vectors++;
            if (seq[i] != exp_seq[i]) begin
                miscompares++;
                $display("FAIL coal_order%0d: got idx %0d, required %0d", i, seq[i], exp_seq[i]);
            end
        end
    endtask

    task automatic test_mute_abort();
        int bad;
        pulse(10'b00_0101_0000);
        step();
        step();
        vectors++;
        if (buzzer !== 1'b1 || cur_idx !== 4'd4) begin
            miscompares++;
            $display("FAIL mute_start: got bz=%b idx=%0d, required bz=1 idx=4", buzzer, cur_idx);
        end
        mute = 1'b1;
        bad = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (buzzer !== 1'b0 || busy !== 1'b1 || cur_idx !== 4'd4) bad++;
        end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL mute_hold: %0d bad cycles, required 0", bad); end
        mute = 1'b0;
        #1;
        vectors++;
        if (buzzer !== 1'b1) begin miscompares++; $display("FAIL unmute: got %b, required 1", buzzer); end
        enable = 1'b0;
        wrap_evt = 10'b01_0000_0000;
        step();
        wrap_evt = '0;
        vectors += 3;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b, required 0", busy); end
        if (buzzer !== 1'b0) begin miscompares++; $display("FAIL abort_buzzer: got %b, required 0", buzzer); end
        if (coalesced !== 1'b1) begin miscompares++; $display("FAIL abort_coalesced: got %b, required 1", coalesced); end
        enable = 1'b1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (busy !== 1'b0 || buzzer !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL abort_flush: %0d busy cycles, required 0", bad); end
    endtask

    task automatic test_reset_mid_gap();
        pulse(10'b00_0000_0100);
        step();
        step();
        repeat (BEEP + 2) step();
        vectors++;
        if (busy !== 1'b1 || buzzer !== 1'b0) begin
            miscompares++;
            $display("FAIL gap_reached: got busy=%b bz=%b, required busy=1 bz=0", busy, buzzer);
        end
        rstn = 1'b0;
        step();
        vectors += 4;
        if (buzzer !== 1'b0) begin miscompares++; $display("FAIL rst2_buzzer: got %b, required 0", buzzer); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rst2_busy: got %b, required 0", busy); end
        if (cur_idx !== 4'd0) begin miscompares++; $display("FAIL rst2_cur_idx: got %0d, required 0", cur_idx); end
        if (coalesced !== 1'b0) begin miscompares++; $display("FAIL rst2_coalesced: got %b, required 0", coalesced); end
        rstn = 1'b1;
        pulse(10'b00_0000_0010);
        step();
        step();
        check_burst(1);
        repeat (3) step();
    endtask

`ifdef WRAP_ALARM_DOUBLE_EN
    task automatic test_double();
        pulse(10'b10_0000_0000);
        step();
        step();
        check_burst(9);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_coalesce();
        test_mute_abort();
        test_reset_mid_gap();
`ifdef WRAP_ALARM_DOUBLE_EN
        test_double();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
